// File: rtl/hh_collector_pkg.sv
// Shared types and sizing helpers for the
// multilane heavy-hash digest collector.
package hh_collector_pkg;

  localparam int HASH_W_WORD    = 64;
  localparam int NLANES_DEF     = 4;
  localparam int NONCE_W_DEF    = 32;
  localparam int HASH_WORDS_DEF = 4;

  function automatic int digest_w(input int words);
    return HASH_W_WORD * words;
  endfunction

  function automatic int lane_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int LANE_W_DEF = lane_w(NLANES_DEF);

  typedef logic [digest_w(HASH_WORDS_DEF)-1:0] digest_t;

  typedef struct packed {
    logic [LANE_W_DEF-1:0]  lane;
    logic [NONCE_W_DEF-1:0] nonce;
  } win_entry_t;

endpackage

// File: rtl/hh_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer
// moves to the lane after the granted one.
module hh_rr_arbiter
  import hh_collector_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = lane_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic          found;
  int            idx;

  // search from the pointer, first requester wins
  always_comb begin
    gnt     = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && en && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        nxt_ptr  = PW'((idx + 1) % N);
      end
    end
  end

  // rotating priority pointer
  always_ff @(posedge clk) begin
    if (!rst) ptr <= '0;
    else      ptr <= nxt_ptr;
  end

endmodule

// File: rtl/heavy_hash_multilane_collector.sv
// Collects digests from parallel heavy-hash lanes,
// compares against a target, queues the winners.
module heavy_hash_multilane_collector
  import hh_collector_pkg::*;
#(
  parameter int NLANES     = NLANES_DEF,
  parameter int NONCE_W    = NONCE_W_DEF,
  parameter int HASH_WORDS = HASH_WORDS_DEF,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             target_we,
  input  logic [digest_w(HASH_WORDS)-1:0]  target_din,
  input  logic [NLANES-1:0]                lane_we,
  input  logic [HASH_W_WORD*NLANES-1:0]    lane_data,
  input  logic [NONCE_W*NLANES-1:0]        lane_nonce,
  output logic [NLANES-1:0]                lane_stall,
  input  logic                             win_re,
  output logic                             win_empty,
  output logic [NONCE_W-1:0]               win_nonce,
  output logic [lane_w(NLANES)-1:0]        win_lane,
  output logic [31:0]                      hash_cnt,
  output logic [31:0]                      win_cnt,
  output logic [15:0]                      drop_cnt
);

  localparam int DW = digest_w(HASH_WORDS);
  localparam int LW = lane_w(NLANES);
  localparam int CW = lane_w(HASH_WORDS);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(HASH_WORDS - 1);

  logic [CW-1:0]      cnt      [NLANES];
  logic [DW-1:0]      asm_q    [NLANES];
  logic [DW-1:0]      full_dig [NLANES];
  logic [DW-1:0]      pend_dig [NLANES];
  logic [NONCE_W-1:0] pend_non [NLANES];
  logic [NLANES-1:0]  pending;
  logic [NLANES-1:0]  last;
  logic [NLANES-1:0]  accept;
  logic [NLANES-1:0]  drop;
  logic [NLANES-1:0]  gnt;
  logic [LW-1:0]      g_idx;
  logic [4:0]         ndrop;
  logic [16:0]        drop_sum;

  logic               s1_valid;
  logic [DW-1:0]      s1_dig;
  logic [NONCE_W-1:0] s1_nonce;
  logic [LW-1:0]      s1_lane;
  logic [DW-1:0]      target;
  logic               win;

  win_entry_t         mem [OUT_DEPTH];
  win_entry_t         wr_ent;
  win_entry_t         head;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        occ;
  logic [AW+1:0]      in_use;
  logic               arb_en;
  logic               push;
  logic               pop;

  // per-lane last-word, accept and drop decode
  always_comb begin
    last       = '0;
    accept     = '0;
    drop       = '0;
    lane_stall = '0;
    ndrop      = '0;
    for (int i = 0; i < NLANES; i++) begin
      full_dig[i] = asm_q[i];
      full_dig[i][int'(cnt[i])*HASH_W_WORD +: HASH_W_WORD] =
        lane_data[i*HASH_W_WORD +: HASH_W_WORD];
      last[i]       = lane_we[i] && (cnt[i] == LAST);
      accept[i]     = last[i] && (!pending[i] || gnt[i]);
      drop[i]       = last[i] && pending[i] && !gnt[i];
      lane_stall[i] = pending[i] && (cnt[i] == LAST);
      ndrop         = ndrop + 5'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(ndrop);
  end

  // word counters and pending flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      for (int i = 0; i < NLANES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        if (lane_we[i])
          cnt[i] <= last[i] ? '0 : cnt[i] + 1'b1;
        if (accept[i])    pending[i] <= 1'b1;
        else if (gnt[i])  pending[i] <= 1'b0;
      end
    end
  end

  // digest assembly and pending slot payload
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (lane_we[i])
        asm_q[i] <= full_dig[i];
      if (accept[i]) begin
        pend_dig[i] <= full_dig[i];
        pend_non[i] <= lane_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

  // grant only while the FIFO can absorb it
  always_comb begin
    in_use = (AW+2)'(occ) + (AW+2)'(s1_valid);
    arb_en = in_use < (AW+2)'(OUT_DEPTH);
    g_idx  = '0;
    for (int i = 0; i < NLANES; i++)
      if (gnt[i]) g_idx = LW'(i);
  end

  hh_rr_arbiter #(.N(NLANES)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (pending),
    .gnt (gnt)
  );

  // stage 1 valid
  always_ff @(posedge clk) begin
    if (!rst) s1_valid <= 1'b0;
    else      s1_valid <= |gnt;
  end

  // stage 1 payload
  always_ff @(posedge clk) begin
    if (|gnt) begin
      s1_dig   <= pend_dig[g_idx];
      s1_nonce <= pend_non[g_idx];
      s1_lane  <= g_idx;
    end
  end

  // target register
  always_ff @(posedge clk) begin
    if (!rst)           target <= '0;
    else if (target_we) target <= target_din;
  end

  // stage 2 compare and FIFO handshake
  always_comb begin
    win          = s1_valid && (s1_dig <= target);
    push         = win;
    pop          = win_re && (occ != '0);
    wr_ent.lane  = LANE_W_DEF'(s1_lane);
    wr_ent.nonce = NONCE_W_DEF'(s1_nonce);
    head         = mem[rptr];
    win_empty    = (occ == '0);
    win_nonce    = win_empty ? '0 : NONCE_W'(head.nonce);
    win_lane     = win_empty ? '0 : LW'(head.lane);
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_ent;
  end

  // FIFO pointers, occupancy and statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      hash_cnt <= '0;
      win_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      occ      <= occ + (AW+1)'(push) - (AW+1)'(pop);
      hash_cnt <= hash_cnt + 32'(s1_valid);
      win_cnt  <= win_cnt + 32'(win);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule
